control_sequencer: RTL and testbench
====================================

# control_sequencer

Hardwired control unit that sits directly upstream of the `cpu_bus` datapath and drives its bus-select, register-enable, memory and ALU-op controls. It fetches an instruction, decodes the opcode and register fields from the IR image, and steps through T-states for register–register ALU, multiply/divide, unary, nop and halt instructions. It replaces hand-sequenced control stimulus with a cycle-exact FSM.

## Interface
- `REGS`, 16: number of general registers; sets the width of the `Rin`/`Rout` one-hot enables.
- `Clock`  in  1  system clock; all state changes on the rising edge.
- `Clear`  in  1  synchronous, active-low reset.
- `IR`  in  32  instruction register contents from the datapath. Fields: op[31:27], ra[26:23], rb[22:19], rc[18:15].
- `MemReady`  in  1  memory has valid data on `Mdatain` this cycle.
- `PCout`, `PCin`, `IncPC`, `MARin`, `Read`, `MDRin`, `MDRout`, `IRin`, `Yin`  out  1 each  datapath controls.
- `ZLowIn`, `ZHighIn`, `Zlowout`, `ZHighout`, `LOin`, `HIin`  out  1 each  Z/LO/HI controls.
- `Rin`, `Rout`  out  REGS  one-hot register load and drive enables.
- `ALUop`  out  5  ALU operation code; equals the opcode in execute states, otherwise 5'b00000.
- `Run`  out  1  high unless halted.
- `IllegalOp`  out  1  one-cycle pulse when an undefined opcode is decoded.

## Operation
- Opcodes:
  - Two-operand: add 00011, sub 00100, shr 00101, shl 00110, ror 00111, rol 01000, and 01001, or 01010.
  - Wide: mul 01110, div 01111.
  - Unary: neg 10000, not 10001.
  - Other: nop 11010, halt 11011. Every other opcode is illegal.
- States: `T0`, `T1`, `T2`, `T3`, `T4`, `T5`, `T6`, `HALT`. Outputs are a Moore decode of the state plus latched IR fields. Every asserted control is held for the whole state cycle.
- Fetch, all instructions:
  - `T0`: `PCout`, `MARin`, `IncPC`, `ZLowIn`.
  - `T1`: `Zlowout`, `PCin`, `Read`. `Read` is held until `MemReady`=1. `MDRin` is asserted only in the cycle where `MemReady`=1, and the FSM advances on that edge.
  - `T2`: `MDRout`, `IRin`.
- Two-operand instructions (ra ← rb op rc):
  - `T3`: `Rout[rb]`, `Yin`.
  - `T4`: `Rout[rc]`, `ALUop`=op, `ZLowIn`.
  - `T5`: `Zlowout`, `Rin[ra]`. Then go to `T0`.
- mul/div (ra, rb):
  - `T3`: `Rout[ra]`, `Yin`.
  - `T4`: `Rout[rb]`, `ALUop`, `ZLowIn`, `ZHighIn`.
  - `T5`: `Zlowout`, `LOin`.
  - `T6`: `ZHighout`, `HIin`. Then go to `T0`.
- neg/not (ra ← op rb):
  - `T3`: `Rout[rb]`, `ALUop`, `ZLowIn`.
  - `T4`: `Zlowout`, `Rin[ra]`. Then go to `T0`.
- nop: `T2` → `T0`.
- halt: `T2` → `HALT`. `HALT` is absorbing, with `Run`=0 and all controls 0. Only `Clear` exits it.
- Illegal opcode: pulse `IllegalOp` in `T3`, drive no other controls, then go to `T0`.
- IR fields are captured at the end of `T2`. A changing `IR` input after that point has no effect until the next fetch.
- At most one bus driver is asserted in any cycle, out of `PCout`, `MDRout`, `Zlowout`, `ZHighout` and any `Rout` bit.
- `Rin` and `Rout` are one-hot or zero. Field index values up to 15 are legal.

## Timing
- Reset: `Clear`=0 at a rising edge sets state to `T0`.
  - During and after reset: all outputs 0 except `Run`=1.
  - The first edge with `Clear`=1 leaves `T0` holding its `T0` outputs.
  - Reset aborts any state, including `HALT` and a pending `T1` wait.
- Cycles per instruction with zero-wait memory: two-operand 6, mul/div 7, unary 5, nop 3, halt 3 then stopped. Each `MemReady` wait cycle adds 1.
- `MemReady`=1 outside `T1` is ignored.
- `Clear`=0 coincident with `MemReady`=1 in `T1`: reset wins and `MDRin` stays 0.

## Test plan
- and, IR=0x4A920000 (op 01001, ra=5, rb=2, rc=4), `MemReady` tied 1:
  - `T3`: `Rout`=0x0004, `Yin`=1.
  - `T4`: `Rout`=0x0010, `ALUop`=01001, `ZLowIn`=1.
  - `T5`: `Zlowout`=1, `Rin`=0x0020.
  - Next cycle is `T0`, 6 cycles in total.
- Fetch wait: hold `MemReady`=0 for 3 cycles in `T1` → `Read`=1 for 4 cycles, `MDRin`=1 only in the 4th, `IRin` one cycle later.
- mul, IR=0x71880000 (ra=3, rb=1):
  - `T3`: `Rout`=0x0008, `Yin`=1.
  - `T4`: `Rout`=0x0002, `ZLowIn`=`ZHighIn`=1.
  - `T5`: `Zlowout`=1, `LOin`=1.
  - `T6`: `ZHighout`=1, `HIin`=1.
- halt, IR=0xD8000000 → `Run`=0 from the cycle after `T2`, all controls 0 for 20 cycles. Then `Clear`=0 for one edge → `Run`=1 and `PCout`=1.
- Illegal, IR=0xF8000000 → `IllegalOp`=1 for exactly one cycle, `Rin`=`Rout`=0, then `T0`.
- Reset mid-`T4` of the and instruction → next cycle all controls 0, then `T0` controls asserted. Every cycle of the test checks the bus-driver mutual-exclusion assertion.

Source files
------------

// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
//
// Hardwired control unit for the cpu_bus datapath. It fetches an instruction,
// captures the opcode and register fields from the IR image at the end of T2,
// and steps through T-states for register-register ALU, multiply/divide,
// unary, nop and halt instructions. Outputs are a Moore decode of the current
// state plus the latched IR fields. The one exception is MDRin in T1, which
// follows MemReady.
//
// Parameters
//   REGS      number of general registers (width of Rin/Rout)
//
// Ports
//   Clock     system clock, rising edge
//   Clear     synchronous active-low reset
//   IR        instruction image: op[31:27] ra[26:23] rb[22:19] rc[18:15]
//   MemReady  memory data valid this cycle (only looked at in T1)
//   PCout .. HIin   single-bit datapath controls
//   Rin/Rout  one-hot (or zero) register load / drive enables
//   ALUop     opcode during ALU execute states, otherwise zero
//   Run       high unless halted
//   IllegalOp one-cycle pulse in T3 for an undefined opcode
// -----------------------------------------------------------------------------
module control_sequencer #(
  parameter int REGS = 16
) (
  input  logic            Clock,
  input  logic            Clear,
  input  logic [31:0]     IR,
  input  logic            MemReady,
  output logic            PCout,
  output logic            PCin,
  output logic            IncPC,
  output logic            MARin,
  output logic            Read,
  output logic            MDRin,
  output logic            MDRout,
  output logic            IRin,
  output logic            Yin,
  output logic            ZLowIn,
  output logic            ZHighIn,
  output logic            Zlowout,
  output logic            ZHighout,
  output logic            LOin,
  output logic            HIin,
  output logic [REGS-1:0] Rin,
  output logic [REGS-1:0] Rout,
  output logic [4:0]      ALUop,
  output logic            Run,
  output logic            IllegalOp
);

  localparam int IDX_W = 4;

  typedef enum logic [2:0] {
    T0, T1, T2, T3, T4, T5, T6, HALT
  } state_t;

  typedef enum logic [2:0] {
    CLS_TWO, CLS_WIDE, CLS_UNARY, CLS_NOP, CLS_HALT, CLS_ILLEGAL
  } class_t;

  // Map an opcode onto the instruction class that selects the T-state path.
  function automatic class_t classify(input logic [4:0] op);
    class_t c;
    c = CLS_ILLEGAL;
    case (op)
      5'b00011, 5'b00100, 5'b00101, 5'b00110,
      5'b00111, 5'b01000, 5'b01001, 5'b01010: c = CLS_TWO;
      5'b01110, 5'b01111:                     c = CLS_WIDE;
      5'b10000, 5'b10001:                     c = CLS_UNARY;
      5'b11010:                               c = CLS_NOP;
      5'b11011:                               c = CLS_HALT;
      default:                                c = CLS_ILLEGAL;
    endcase
    return c;
  endfunction

  state_t           state_reg;
  state_t           state_next;
  logic             hold_reg;     // set by reset: T0 with outputs quiet for one cycle
  logic [4:0]       op_reg;
  logic [IDX_W-1:0] ra_reg;
  logic [IDX_W-1:0] rb_reg;
  logic [IDX_W-1:0] rc_reg;

  class_t           ir_class;     // class of the live IR input (used in T2)
  class_t           op_class;     // class of the captured opcode (T3 onward)
  logic             ctrl_en;

  logic             rout_en;
  logic [IDX_W-1:0] rout_idx;
  logic             rin_en;
  logic [IDX_W-1:0] rin_idx;

  // Only the opcode and the three register fields are decoded.
  logic unused_ir_bits;
  assign unused_ir_bits = ^IR[14:0];

  assign ir_class = classify(IR[31:27]);
  assign op_class = classify(op_reg);

  // Controls are suppressed while Clear is low (so reset always wins, e.g.
  // over MDRin in a T1 wait) and in the quiet cycle right after reset.
  assign ctrl_en = Clear && !hold_reg;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clock) begin
    if (!Clear) begin
      state_reg <= T0;
      hold_reg  <= 1'b1;
    end else begin
      state_reg <= state_next;
      hold_reg  <= 1'b0;
    end
  end

  // IR fields are latched on the edge that leaves T2, so later IR changes
  // have no effect until the next fetch.
  always_ff @(posedge Clock) begin
    if (!Clear) begin
      op_reg <= 5'b00000;
      ra_reg <= '0;
      rb_reg <= '0;
      rc_reg <= '0;
    end else if (!hold_reg && state_reg == T2) begin
      op_reg <= IR[31:27];
      ra_reg <= IR[26:23];
      rb_reg <= IR[22:19];
      rc_reg <= IR[18:15];
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    if (hold_reg) begin
      // First active edge after reset stays in T0 and enables its outputs.
      state_next = T0;
    end else begin
      case (state_reg)
        T0: state_next = T1;
        T1: if (MemReady) state_next = T2;
        T2: begin
          case (ir_class)
            CLS_NOP:  state_next = T0;
            CLS_HALT: state_next = HALT;
            default:  state_next = T3;
          endcase
        end
        T3: begin
          if (op_class == CLS_ILLEGAL) state_next = T0;
          else                         state_next = T4;
        end
        T4: begin
          if (op_class == CLS_UNARY) state_next = T0;
          else                       state_next = T5;
        end
        T5: begin
          if (op_class == CLS_WIDE) state_next = T6;
          else                      state_next = T0;
        end
        T6:      state_next = T0;
        HALT:    state_next = HALT;
        default: state_next = T0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    PCout     = 1'b0;
    PCin      = 1'b0;
    IncPC     = 1'b0;
    MARin     = 1'b0;
    Read      = 1'b0;
    MDRin     = 1'b0;
    MDRout    = 1'b0;
    IRin      = 1'b0;
    Yin       = 1'b0;
    ZLowIn    = 1'b0;
    ZHighIn   = 1'b0;
    Zlowout   = 1'b0;
    ZHighout  = 1'b0;
    LOin      = 1'b0;
    HIin      = 1'b0;
    ALUop     = 5'b00000;
    IllegalOp = 1'b0;
    rout_en   = 1'b0;
    rout_idx  = '0;
    rin_en    = 1'b0;
    rin_idx   = '0;

    if (ctrl_en) begin
      case (state_reg)
        T0: begin
          PCout  = 1'b1;
          MARin  = 1'b1;
          IncPC  = 1'b1;
          ZLowIn = 1'b1;
        end
        T1: begin
          Zlowout = 1'b1;
          PCin    = 1'b1;
          Read    = 1'b1;
          MDRin   = MemReady;
        end
        T2: begin
          MDRout = 1'b1;
          IRin   = 1'b1;
        end
        T3: begin
          case (op_class)
            CLS_TWO: begin
              rout_en  = 1'b1;
              rout_idx = rb_reg;
              Yin      = 1'b1;
            end
            CLS_WIDE: begin
              rout_en  = 1'b1;
              rout_idx = ra_reg;
              Yin      = 1'b1;
            end
            CLS_UNARY: begin
              rout_en  = 1'b1;
              rout_idx = rb_reg;
              ALUop    = op_reg;
              ZLowIn   = 1'b1;
            end
            CLS_ILLEGAL: IllegalOp = 1'b1;
            default: ;
          endcase
        end
        T4: begin
          case (op_class)
            CLS_TWO: begin
              rout_en  = 1'b1;
              rout_idx = rc_reg;
              ALUop    = op_reg;
              ZLowIn   = 1'b1;
            end
            CLS_WIDE: begin
              rout_en  = 1'b1;
              rout_idx = rb_reg;
              ALUop    = op_reg;
              ZLowIn   = 1'b1;
              ZHighIn  = 1'b1;
            end
            CLS_UNARY: begin
              Zlowout = 1'b1;
              rin_en  = 1'b1;
              rin_idx = ra_reg;
            end
            default: ;
          endcase
        end
        T5: begin
          case (op_class)
            CLS_TWO: begin
              Zlowout = 1'b1;
              rin_en  = 1'b1;
              rin_idx = ra_reg;
            end
            CLS_WIDE: begin
              Zlowout = 1'b1;
              LOin    = 1'b1;
            end
            default: ;
          endcase
        end
        T6: begin
          if (op_class == CLS_WIDE) begin
            ZHighout = 1'b1;
            HIin     = 1'b1;
          end
        end
        default: ;  // HALT: everything stays 0
      endcase
    end
  end

  // Run drops only in HALT; while Clear is asserted the unit is considered
  // running again.
  assign Run = (state_reg != HALT) || !Clear;

  // One-hot register enables from the selected field index. Registers beyond
  // the reach of a 4-bit field can never be selected.
  for (genvar gi = 0; gi < REGS; gi++) begin : g_reg_sel
    if (gi < (1 << IDX_W)) begin : g_live
      assign Rout[gi] = rout_en && (rout_idx == IDX_W'(gi));
      assign Rin[gi]  = rin_en  && (rin_idx  == IDX_W'(gi));
    end else begin : g_dead
      assign Rout[gi] = 1'b0;
      assign Rin[gi]  = 1'b0;
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// -----------------------------------------------------------------------------
// tb_control_sequencer
//
// Directed testbench for control_sequencer. Each task drives one scenario and
// compares outputs inline against hand-computed values. Inputs are driven and
// outputs sampled 1 time unit after the rising edge. A negedge monitor checks
// bus-driver exclusivity and Rin one-hotness every cycle.
//
// Control vector bit order (MSB..LSB):
//   PCout PCin IncPC MARin Read MDRin MDRout IRin Yin ZLowIn ZHighIn Zlowout
//   ZHighout LOin HIin IllegalOp
// -----------------------------------------------------------------------------
module tb_control_sequencer;

  logic        Clock;
  logic        Clear;
  logic [31:0] IR;
  logic        MemReady;
  logic        PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin, Yin;
  logic        ZLowIn, ZHighIn, Zlowout, ZHighout, LOin, HIin;
  logic [15:0] Rin, Rout;
  logic [4:0]  ALUop;
  logic        Run, IllegalOp;

  int checks = 0;
  int errors = 0;
  bit mon_en = 0;

  localparam logic [15:0] C_T0     = 16'hB040;
  localparam logic [15:0] C_T1_RDY = 16'h4C10;
  localparam logic [15:0] C_T1_WT  = 16'h4810;
  localparam logic [15:0] C_T2     = 16'h0300;
  localparam logic [15:0] C_YIN    = 16'h0080;
  localparam logic [15:0] C_ZLIN   = 16'h0040;
  localparam logic [15:0] C_ZLOUT  = 16'h0010;
  localparam logic [15:0] C_W4     = 16'h0060;
  localparam logic [15:0] C_W5     = 16'h0014;
  localparam logic [15:0] C_W6     = 16'h000A;
  localparam logic [15:0] C_ILL    = 16'h0001;

  control_sequencer #(.REGS(16)) dut (
    .Clock    (Clock),
    .Clear    (Clear),
    .IR       (IR),
    .MemReady (MemReady),
    .PCout    (PCout),
    .PCin     (PCin),
    .IncPC    (IncPC),
    .MARin    (MARin),
    .Read     (Read),
    .MDRin    (MDRin),
    .MDRout   (MDRout),
    .IRin     (IRin),
    .Yin      (Yin),
    .ZLowIn   (ZLowIn),
    .ZHighIn  (ZHighIn),
    .Zlowout  (Zlowout),
    .ZHighout (ZHighout),
    .LOin     (LOin),
    .HIin     (HIin),
    .Rin      (Rin),
    .Rout     (Rout),
    .ALUop    (ALUop),
    .Run      (Run),
    .IllegalOp(IllegalOp)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic logic [15:0] ctrl_vec();
    return {PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin, Yin,
            ZLowIn, ZHighIn, Zlowout, ZHighout, LOin, HIin, IllegalOp};
  endfunction

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // Per-cycle structural checks.
  always @(negedge Clock) begin
    if (mon_en) begin
      int drv;
      drv = int'(PCout) + int'(MDRout) + int'(Zlowout) + int'(ZHighout) + $countones(Rout);
      checks++;
      if (drv > 1) begin
        errors++;
        $display("FAIL bus_excl t=%0t drivers=%0d max=1", $time, drv);
      end
      checks++;
      if ($countones(Rin) > 1) begin
        errors++;
        $display("FAIL rin_onehot t=%0t Rin=%h exp=onehot_or_zero", $time, Rin);
      end
    end
  end

  task automatic test_reset();
    Clear = 1'b0; MemReady = 1'b0; IR = 32'h0;
    step();
    checks++;
    if (ctrl_vec() !== 16'h0 || Rin !== 16'h0 || Rout !== 16'h0 || ALUop !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl ctrl=%h Rin=%h Rout=%h ALUop=%b exp=0", ctrl_vec(), Rin, Rout, ALUop);
    end
    checks++;
    if (Run !== 1'b1) begin errors++; $display("FAIL reset_run Run=%b exp=1", Run); end
    mon_en = 1'b1;
    Clear = 1'b1;
    #1;
    checks++;
    if (ctrl_vec() !== 16'h0) begin
      errors++;
      $display("FAIL reset_quiet ctrl=%h exp=0000", ctrl_vec());
    end
    step();
    checks++;
    if (ctrl_vec() !== C_T0 || Run !== 1'b1) begin
      errors++;
      $display("FAIL reset_t0 ctrl=%h Run=%b exp=%h/1", ctrl_vec(), Run, C_T0);
    end
    $display("test_reset done");
  endtask

  // Starts and ends in T0.
  task automatic test_and();
    IR = 32'h4A920000; MemReady = 1'b1;
    step();
    checks++;
    if (ctrl_vec() !== C_T1_RDY) begin errors++; $display("FAIL and_t1 ctrl=%h exp=%h", ctrl_vec(), C_T1_RDY); end
    step();
    checks++;
    if (ctrl_vec() !== C_T2) begin errors++; $display("FAIL and_t2 ctrl=%h exp=%h", ctrl_vec(), C_T2); end
    step();
    checks++;
    if (ctrl_vec() !== C_YIN || Rout !== 16'h0004 || Rin !== 16'h0 || ALUop !== 5'b0) begin
      errors++;
      $display("FAIL and_t3 ctrl=%h Rout=%h Rin=%h ALUop=%b exp=%h/0004/0000/00000", ctrl_vec(), Rout, Rin, ALUop, C_YIN);
    end
    step();
    checks++;
    if (ctrl_vec() !== C_ZLIN || Rout !== 16'h0010 || ALUop !== 5'b01001) begin
      errors++;
      $display("FAIL and_t4 ctrl=%h Rout=%h ALUop=%b exp=%h/0010/01001", ctrl_vec(), Rout, ALUop, C_ZLIN);
    end
    step();
    checks++;
    if (ctrl_vec() !== C_ZLOUT || Rin !== 16'h0020 || Rout !== 16'h0 || ALUop !== 5'b0) begin
      errors++;
      $display("FAIL and_t5 ctrl=%h Rin=%h Rout=%h ALUop=%b exp=%h/0020/0000/00000", ctrl_vec(), Rin, Rout, ALUop, C_ZLOUT);
    end
    step();
    checks++;
    if (ctrl_vec() !== C_T0 || Rin !== 16'h0 || ALUop !== 5'b0) begin
      errors++;
      $display("FAIL and_next_t0 ctrl=%h Rin=%h ALUop=%b exp=%h/0000/00000", ctrl_vec(), Rin, ALUop, C_T0);
    end
    $display("test_and done");
  endtask

  // Three MemReady wait cycles in T1, with a nop fetched; starts/ends in T0.
  task automatic test_fetch_wait();
    IR = 32'hD0000000; MemReady = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ctrl_vec() !== C_T1_WT) begin
        errors++;
        $display("FAIL wait_t1_%0d ctrl=%h exp=%h", i, ctrl_vec(), C_T1_WT);
      end
      step();
    end
    MemReady = 1'b1;
    #1;
    checks++;
    if (ctrl_vec() !== C_T1_RDY) begin errors++; $display("FAIL wait_t1_ready ctrl=%h exp=%h", ctrl_vec(), C_T1_RDY); end
    step();
    checks++;
    if (ctrl_vec() !== C_T2) begin errors++; $display("FAIL wait_t2 ctrl=%h exp=%h", ctrl_vec(), C_T2); end
    step();
    checks++;
    if (ctrl_vec() !== C_T0) begin errors++; $display("FAIL nop_to_t0 ctrl=%h exp=%h", ctrl_vec(), C_T0); end
    $display("test_fetch_wait done");
  endtask

  task automatic test_mul();
    IR = 32'h71880000; MemReady = 1'b1;
    step(); step(); step();
    checks++;
    if (ctrl_vec() !== C_YIN || Rout !== 16'h0008) begin
      errors++;
      $display("FAIL mul_t3 ctrl=%h Rout=%h exp=%h/0008", ctrl_vec(), Rout, C_YIN);
    end
    step();
    checks++;
    if (ctrl_vec() !== C_W4 || Rout !== 16'h0002 || ALUop !== 5'b01110) begin
      errors++;
      $display("FAIL mul_t4 ctrl=%h Rout=%h ALUop=%b exp=%h/0002/01110", ctrl_vec(), Rout, ALUop, C_W4);
    end
    step();
    checks++;
    if (ctrl_vec() !== C_W5 || Rout !== 16'h0 || Rin !== 16'h0) begin
      errors++;
      $display("FAIL mul_t5 ctrl=%h Rout=%h Rin=%h exp=%h/0000/0000", ctrl_vec(), Rout, Rin, C_W5);
    end
    step();
    checks++;
    if (ctrl_vec() !== C_W6) begin errors++; $display("FAIL mul_t6 ctrl=%h exp=%h", ctrl_vec(), C_W6); end
    step();
    checks++;
    if (ctrl_vec() !== C_T0) begin errors++; $display("FAIL mul_next_t0 ctrl=%h exp=%h", ctrl_vec(), C_T0); end
    $display("test_mul done");
  endtask

  // neg r7 <- r15; IR is scrambled after capture and must not matter.
  task automatic test_unary();
    IR = 32'h83F80000; MemReady = 1'b1;
    step(); step(); step();
    IR = 32'h4A920000;
    #1;
    checks++;
    if (ctrl_vec() !== C_ZLIN || Rout !== 16'h8000 || ALUop !== 5'b10000) begin
      errors++;
      $display("FAIL neg_t3 ctrl=%h Rout=%h ALUop=%b exp=%h/8000/10000", ctrl_vec(), Rout, ALUop, C_ZLIN);
    end
    step();
    checks++;
    if (ctrl_vec() !== C_ZLOUT || Rin !== 16'h0080 || Rout !== 16'h0) begin
      errors++;
      $display("FAIL neg_t4 ctrl=%h Rin=%h Rout=%h exp=%h/0080/0000", ctrl_vec(), Rin, Rout, C_ZLOUT);
    end
    step();
    checks++;
    if (ctrl_vec() !== C_T0) begin errors++; $display("FAIL neg_next_t0 ctrl=%h exp=%h", ctrl_vec(), C_T0); end
    $display("test_unary done");
  endtask

  task automatic test_illegal();
    IR = 32'hF8000000; MemReady = 1'b1;
    step(); step();
    checks++;
    if (IllegalOp !== 1'b0) begin errors++; $display("FAIL ill_t2 IllegalOp=%b exp=0", IllegalOp); end
    step();
    checks++;
    if (ctrl_vec() !== C_ILL || Rin !== 16'h0 || Rout !== 16'h0 || ALUop !== 5'b0) begin
      errors++;
      $display("FAIL ill_t3 ctrl=%h Rin=%h Rout=%h ALUop=%b exp=%h/0000/0000/00000", ctrl_vec(), Rin, Rout, ALUop, C_ILL);
    end
    step();
    checks++;
    if (ctrl_vec() !== C_T0) begin errors++; $display("FAIL ill_next_t0 ctrl=%h exp=%h", ctrl_vec(), C_T0); end
    $display("test_illegal done");
  endtask

  // Back-to-back into reset: and instruction interrupted in T4.
  task automatic test_reset_mid();
    IR = 32'h4A920000; MemReady = 1'b1;
    step(); step(); step(); step();
    checks++;
    if (ALUop !== 5'b01001) begin errors++; $display("FAIL mid_in_t4 ALUop=%b exp=01001", ALUop); end
    Clear = 1'b0;
    step();
    Clear = 1'b1;
    #1;
    checks++;
    if (ctrl_vec() !== 16'h0 || Rin !== 16'h0 || Rout !== 16'h0 || Run !== 1'b1) begin
      errors++;
      $display("FAIL mid_quiet ctrl=%h Rin=%h Rout=%h Run=%b exp=0/0/0/1", ctrl_vec(), Rin, Rout, Run);
    end
    step();
    checks++;
    if (ctrl_vec() !== C_T0) begin errors++; $display("FAIL mid_t0 ctrl=%h exp=%h", ctrl_vec(), C_T0); end
    $display("test_reset_mid done");
  endtask

  // Clear low together with MemReady high in T1.
  task automatic test_reset_vs_ready();
    IR = 32'hD0000000; MemReady = 1'b1;
    step();
    Clear = 1'b0;
    #1;
    checks++;
    if (MDRin !== 1'b0) begin errors++; $display("FAIL rst_ready_mdrin MDRin=%b exp=0", MDRin); end
    step();
    Clear = 1'b1;
    step();
    checks++;
    if (ctrl_vec() !== C_T0) begin errors++; $display("FAIL rst_ready_t0 ctrl=%h exp=%h", ctrl_vec(), C_T0); end
    step();
    checks++;
    if (ctrl_vec() !== C_T1_RDY) begin errors++; $display("FAIL rst_ready_t1 ctrl=%h exp=%h", ctrl_vec(), C_T1_RDY); end
    step(); step();
    $display("test_reset_vs_ready done");
  endtask

  task automatic test_halt();
    IR = 32'hD8000000; MemReady = 1'b1;
    step(); step();
    checks++;
    if (Run !== 1'b1) begin errors++; $display("FAIL halt_t2_run Run=%b exp=1", Run); end
    for (int i = 0; i < 20; i++) begin
      step();
      MemReady = i[0];
      checks++;
      if (Run !== 1'b0 || ctrl_vec() !== 16'h0 || Rin !== 16'h0 || Rout !== 16'h0 || ALUop !== 5'b0) begin
        errors++;
        $display("FAIL halt_hold_%0d Run=%b ctrl=%h Rin=%h Rout=%h ALUop=%b exp=0", i, Run, ctrl_vec(), Rin, Rout, ALUop);
      end
    end
    Clear = 1'b0;
    step();
    Clear = 1'b1;
    #1;
    checks++;
    if (Run !== 1'b1 || ctrl_vec() !== 16'h0) begin
      errors++;
      $display("FAIL halt_clear Run=%b ctrl=%h exp=1/0000", Run, ctrl_vec());
    end
    step();
    checks++;
    if (PCout !== 1'b1 || ctrl_vec() !== C_T0) begin
      errors++;
      $display("FAIL halt_restart ctrl=%h exp=%h", ctrl_vec(), C_T0);
    end
    $display("test_halt done");
  endtask

  initial begin
    Clear = 1'b0; MemReady = 1'b0; IR = 32'h0;
    test_reset();
    test_and();
    test_fetch_wait();
    test_mul();
    test_unary();
    test_illegal();
    test_reset_mid();
    test_reset_vs_ready();
    test_halt();
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t exp=finish_before_timeout", $time);
    $fatal(1, "timeout");
  end

endmodule
